// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter driving the select (S16) and one-hot grant of a shared 16:1 mux.
// Optional forced release after MAX_HOLD cycles: define HOLD_TIMEOUT_EN.
module mux16_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 8
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  S16,
  output logic [15:0] gnt,
  output logic        busy,
  output logic        timeout
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  if (MAX_HOLD < 1 || MAX_HOLD > 255 || (2 ** CW) <= MAX_HOLD) begin : g_bad_param
    $error("mux16_rr_arbiter: MAX_HOLD must be 1..255 and fit in CW bits");
  end

  logic [1:0] state;
  logic [3:0] last;
  logic [3:0] pick;
  logic       rel;

  // First set request scanning upward from last+1, wrapping 15->0.
  function automatic logic [3:0] rr_pick(input logic [15:0] r, input logic [3:0] ptr);
    logic [3:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      idx = ptr + 4'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign pick = rr_pick(req, last);
  assign rel  = done || !req[S16];

`ifdef HOLD_TIMEOUT_EN
  logic [CW-1:0] cnt;
  logic          tmo;
  assign tmo = !rel && (cnt == CW'(MAX_HOLD - 1));
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      S16     <= 4'd0;
      gnt     <= 16'h0000;
      busy    <= 1'b0;
      timeout <= 1'b0;
      last    <= 4'd15;
`ifdef HOLD_TIMEOUT_EN
      cnt     <= '0;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            S16   <= pick;
            gnt   <= 16'(1) << pick;
            busy  <= 1'b1;
            last  <= pick;
            state <= GRANT;
`ifdef HOLD_TIMEOUT_EN
            cnt   <= '0;
`endif
          end
        end
        GRANT: begin
`ifdef HOLD_TIMEOUT_EN
          if (cnt != '1) cnt <= cnt + CW'(1);
`endif
          // Grant drops on the exit edge so the select never moves under an active grant.
          if (rel) begin
            gnt   <= 16'h0000;
            busy  <= 1'b0;
            state <= RELEASE;
          end
`ifdef HOLD_TIMEOUT_EN
          else if (tmo) begin
            gnt     <= 16'h0000;
            busy    <= 1'b0;
            timeout <= 1'b1;
            state   <= RELEASE;
          end
`endif
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
